shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier: the companion of the restoring divider in the arithmetic library, computing P = A×B (optionally A×B + C, which rebuilds a dividend from quotient, divisor and remainder). One multiplier bit is processed per clock. A start/busy/done handshake lets a controller issue one operation at a time. The block is intended to be paired with the divider for round-trip checking and for fixed-point scaling.

## Interface
- N, default 8: operand width; result is 2N bits; N ≥ 2.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_en  input  1  start request; sampled only in IDLE.
- data_A  input  N  multiplicand (unsigned).
- data_B  input  N  multiplier (unsigned).
- data_C  input  N  addend (unsigned); port present only with MUL_ADD_EN.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; data_P is valid in that cycle.
- data_P  output  2N  last result; held until the next completion or reset.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_en=1 captures A_r←data_A.
  - Accumulator P_r←{C or 0, data_B}, 2N bits, plus a carry bit.
  - cnt←0; go to CALC.
  - in_en=0 keeps the state in IDLE.
- CALC, one iteration per cycle:
  - sum = {1'b0, P_r[2N-1:N]} + (P_r[0] ? A_r : 0), N+1 bits.
  - P_r←{sum, P_r[N-1:1]}, a right shift of the whole 2N+1 value.
  - cnt←cnt+1.
  - When cnt==N-1 the iteration completes: data_P←new P_r value; go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- in_en is ignored while busy=1, including the DONE cycle; no queuing.
- Operands are sampled only at the accept edge; later input changes have no effect.
- Arithmetic is exact; no overflow is possible:
  - (2^N−1)² < 2^2N.
  - (2^N−1)² + (2^N−1) = 2^2N − 2^N < 2^2N.
- Zero operands take the full N cycles; there is no early termination.
- cnt width is $clog2(N).

## Timing
- Reset values: busy=0, done=0, data_P=0, state=IDLE; internal registers are all 0.
- Reset takes effect immediately, including mid-CALC or in the DONE cycle. The operation is discarded with no done pulse.
- in_en=1 at IDLE edge k: busy=1 from after edge k.
- CALC iterations occur at edges k+1 … k+N.
- done=1 and the new data_P appear after edge k+N.
- Return to IDLE (busy=0) occurs after edge k+N+1.
- Earliest next accept is edge k+N+2, giving a throughput of one operation per N+2 cycles.
- data_P changes only at the edge entering DONE, or on reset.

## Configuration
- Macro: MUL_ADD_EN.
- Defined: the data_C port exists; the accumulator upper half is initialised with data_C; result = A×B + C.
- Undefined: the data_C port is absent; the upper half is initialised to 0; result = A×B.
- Latency and handshake are identical in both builds.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the width helper for the counter.
- One sub-module, mul_step, is combinational: it performs a single add-and-shift iteration from (P_r, carry, A_r) to the next P_r. The top level contains the FSM, counter and result register.

## Test plan
- N=8, A=13, B=11: done after edge k+8, data_P=143 (0x008F), busy low after k+9.
- A=255, B=255: data_P=0xFE01. With MUL_ADD_EN and C=255: data_P=0xFF00.
- A=0, B=200, then A=200, B=0: both give data_P=0, each after the full 8 iterations.
- Hold in_en=1 continuously with changing operands:
  - accepts occur only at IDLE edges, every 10 cycles;
  - each result matches the operands sampled at its accept edge;
  - in_en is ignored in CALC and DONE.
- Assert rst at the 4th CALC cycle of 100×3:
  - all outputs go to 0 at once, with no done pulse;
  - after release, 7×9 gives 63.
- Hold data_P after done for 20 idle cycles while the inputs toggle: data_P stays constant.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Counter wide enough to hold 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One add-and-shift iteration of the multiplier accumulator (purely combinational).
module mul_step #(
  parameter int N = 8
) (
  input  logic [2*N-1:0] p_i,
  input  logic           carry_i,
  input  logic [N-1:0]   a_i,
  output logic [2*N-1:0] p_o,
  output logic           carry_o
);

  logic [N:0] sum;

  // The add result is N+1 bits wide; shifting the whole {carry, P} right keeps the product exact.
  always_comb begin
    sum            = {carry_i, p_i[2*N-1:N]} + (p_i[0] ? {1'b0, a_i} : '0);
    {carry_o, p_o} = {1'b0, sum, p_i[N-1:1]};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define MUL_ADD_EN to add the data_C port and compute A*B + C instead of A*B.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_en,
  input  logic [N-1:0]   data_A,
  input  logic [N-1:0]   data_B,
`ifdef MUL_ADD_EN
  input  logic [N-1:0]   data_C,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] data_P
);

  localparam int CNT_W = cntWidth(N);

  state_e           state_q;
  logic [N-1:0]     aReg_q;
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   acc_d;
  logic             carry_q;
  logic             carry_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [2*N-1:0]   prod_q;
  logic [N-1:0]     upperInit;

`ifdef MUL_ADD_EN
  assign upperInit = data_C;
`else
  assign upperInit = '0;
`endif

  mul_step #(.N(N)) u_step (
    .p_i     (acc_q),
    .carry_i (carry_q),
    .a_i     (aReg_q),
    .p_o     (acc_d),
    .carry_o (carry_d)
  );

  // Operands are captured only on the accept edge; in_en is ignored outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aReg_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_en) begin
            aReg_q  <= data_A;
            acc_q   <= {upperInit, data_B};
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            prod_q  <= acc_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign data_P = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table plus handshake/reset/hold sequences.
// Works with or without MUL_ADD_EN defined.
module tb_shift_add_multiplier;

  localparam int N  = 8;
  localparam int PW = 2 * N;
`ifdef MUL_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [N-1:0]  c;
    logic [PW-1:0] prod;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          inEn;
  logic [N-1:0]  dataA;
  logic [N-1:0]  dataB;
`ifdef MUL_ADD_EN
  logic [N-1:0]  dataC;
`endif
  logic          busy;
  logic          done;
  logic [PW-1:0] dataP;

  int            checks;
  int            failures;
  logic [PW-1:0] expQ[$];
  logic [PW-1:0] lastExp;

  shift_add_multiplier #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_en  (inEn),
    .data_A (dataA),
    .data_B (dataB),
`ifdef MUL_ADD_EN
    .data_C (dataC),
`endif
    .busy   (busy),
    .done   (done),
    .data_P (dataP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] expFor(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] c);
    return PW'(a) * PW'(b) + (ADD_EN ? PW'(c) : PW'(0));
  endfunction

  task automatic driveOps(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    dataA = a;
    dataB = b;
`ifdef MUL_ADD_EN
    dataC = c;
`else
    if (c != c) dataA = a;
`endif
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", done, 0);
      end else begin
        lastExp = expQ.pop_front();
        checkOutput("result", dataP, lastExp);
      end
    end
  end

  // One full operation with handshake and latency checks; inputs are scrambled after accept.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] c, input logic [PW-1:0] exp);
    int lat;
    bit seen;
    lat = 0;
    while (busy && lat < 4 * N) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("idle_before_start", busy, 0);
    driveOps(a, b, c);
    inEn = 1'b1;
    expQ.push_back(exp);
    @(negedge clk);
    inEn = 1'b0;
    checkOutput("busy_after_accept", busy, 1);
    driveOps(N'($urandom), N'($urandom), N'($urandom));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 3 * N) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    checkOutput("latency", lat, N);
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [PW-1:0] heldP;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  c: 8'd0,   prod: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, prod: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, c: 8'd17,  prod: 16'd0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   c: 8'd33,  prod: 16'd0};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   c: 8'd0,   prod: 16'd1};
    vecs[5] = '{a: 8'd128, b: 8'd2,   c: 8'd0,   prod: 16'd256};
    vecs[6] = '{a: 8'd255, b: 8'd1,   c: 8'd0,   prod: 16'd255};
    vecs[7] = '{a: 8'd3,   b: 8'd170, c: 8'd9,   prod: 16'd510};

    checks   = 0;
    failures = 0;
    lastExp  = '0;
    rst      = 1'b1;
    inEn     = 1'b0;
    driveOps('0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_P", dataP, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].prod + (ADD_EN ? PW'(vecs[i].c) : PW'(0)));
    end

    // in_en held high: accepts only every N+2 edges, operands change every cycle.
    inEn = 1'b1;
    for (int e = 0; e < 4 * (N + 2); e++) begin
      a = N'($urandom);
      b = N'($urandom);
      c = N'($urandom);
      driveOps(a, b, c);
      if (e % (N + 2) == 0) expQ.push_back(expFor(a, b, c));
      @(negedge clk);
      checkOutput("cont_busy", busy, ((e % (N + 2)) <= N) ? 1 : 0);
    end
    inEn = 1'b0;
    @(negedge clk);
    checkOutput("cont_queue_drained", expQ.size(), 0);

    // Reset during the 4th CALC cycle of 100*3 discards the operation.
    driveOps(8'd100, 8'd3, 8'd0);
    inEn = 1'b1;
    @(negedge clk);
    inEn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_mid_calc", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_P", dataP, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("done_during_reset", done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'd7, 8'd9, 8'd0, 16'd63);

    // Result must hold through idle cycles while operands toggle.
    heldP = lastExp;
    for (int i = 0; i < 20; i++) begin
      driveOps(N'($urandom), N'($urandom), N'($urandom));
      @(negedge clk);
      checkOutput("hold_P", dataP, heldP);
    end

    checkOutput("final_queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
